i2c_mem_arbiter: RTL and testbench
==================================

Name: i2c_mem_arbiter

Overview:
- Shares one free-running i2c_mem core between NREQ requesters using round-robin arbitration, one outstanding transaction.
- Latches the winner's command and holds it stable on the core's wr/addr/din inputs.
- The core restarts a transfer on its own after every done, so the first done after a command is loaded is discarded; the second done returns the read data to the requester.
- Watchdog aborts a transaction if the core stops completing.

Parameters:
- NREQ, 4, number of requesters (2..8).
- TIMEOUT_CYC, 1024, max cycles in FLUSH+WAIT before abort; counter width clog2(TIMEOUT_CYC+1).

Ports:
- clk  in  1  clock, all state on posedge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  request pending per requester; held with payload until req_ready.
- req_wr  in  NREQ  1=write, 0=read.
- req_addr  in  7*NREQ  packed word address, requester i at [7i+6:7i].
- req_din  in  8*NREQ  packed write data, requester i at [8i+7:8i].
- req_ready  out  NREQ  one-cycle accept pulse to the winner.
- rsp_valid  out  NREQ  one-cycle completion pulse to the owner.
- rsp_rdata  out  8  read data, valid with rsp_valid; 0 for writes and errors.
- rsp_err  out  1  timeout flag, valid with rsp_valid.
- mem_wr  out  1  to core wr.
- mem_addr  out  7  to core addr.
- mem_din  out  8  to core din.
- mem_datard  in  8  from core datard.
- mem_done  in  1  from core done.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (async, any state):
  - state=IDLE; rr pointer=NREQ-1, so requester 0 wins first.
  - All outputs 0: req_ready, rsp_valid, rsp_rdata, rsp_err, mem_wr, mem_addr, mem_din, busy.
  - Any in-flight transaction is dropped with no response.
- mem_done is edge-qualified. done_rise = mem_done & ~mem_done_q, with mem_done_q a registered copy (reset 0).
- States:
  - IDLE: if |req_valid, winner w = first set bit scanning from pointer+1 modulo NREQ.
    - Next edge: latch mem_wr/mem_addr/mem_din from w's payload; pulse req_ready[w] for 1 cycle; store owner=w; pointer=w; clear timer; go FLUSH.
    - If no request, stay in IDLE.
  - FLUSH: wait for done_rise, which closes a transfer started before or at the command change. Then go WAIT; timer keeps running.
  - WAIT: on done_rise, capture rsp_rdata = mem_wr ? 0 : mem_datard and set rsp_err=0; go RESP.
  - Timeout: in FLUSH or WAIT, timer == TIMEOUT_CYC-1 without the awaited done_rise → rsp_err=1, rsp_rdata=0; go RESP. If done_rise and timeout hit in the same cycle, done_rise wins.
  - RESP: rsp_valid[owner]=1 for exactly one cycle, then IDLE. rsp_rdata/rsp_err hold their values until the next RESP.
- Command stability: mem_wr/mem_addr/mem_din change only on the IDLE→FLUSH edge and are stable through FLUSH, WAIT and RESP.
- Latency:
  - Accept: 1 cycle after valid is seen in IDLE.
  - Next accept: earliest 1 cycle after RESP, so at most one grant per NREQ+ transactions per requester when all contend.
- Requester rules:
  - Dropping req_valid before req_ready is illegal; the arbiter only samples in IDLE.
  - A requester may reassert for its next transaction in the cycle after req_ready.
  - Fairness: with all requesters valid, grant order is 0,1,..,NREQ-1,0,...
- Timer counts every cycle in FLUSH and WAIT, saturates at TIMEOUT_CYC-1, and clears on accept.

Test Plan:
- Single write then read: req 2 writes addr 0x15 din 0xA5, then reads 0x15 → req_ready[2] pulses once each; rsp_valid[2] twice; read rsp_rdata=0xA5, rsp_err=0; exactly two done_rise observed per transaction.
- Round-robin: all 4 valid continuously, each reading its own address → grant order 0,1,2,3,0; no requester granted twice before the others.
- Command stability: during a granted write, monitor mem_addr/mem_din/mem_wr from accept to rsp_valid → no change; core mem[addr] holds the written value.
- Timeout: TIMEOUT_CYC=16, mem_done tied 0 → rsp_valid[owner] 16 cycles after accept, rsp_err=1, rsp_rdata=0; next request accepted normally.
- Async reset in WAIT: assert rst mid-transaction → outputs 0 immediately, no rsp_valid; after release, a pending req 0 is accepted first.
- Done/timeout collision: force done_rise on the timer's last WAIT cycle → rsp_err=0, data captured.

Source files
------------

// File: rtl/i2c_mem_arbiter.sv
// Round-robin front end sharing one free-running i2c_mem core between NREQ
// requesters. One transaction is in flight at a time: the winner's command is
// latched onto the core inputs, the first done after the command change is
// discarded, the second done returns data, and a watchdog aborts stalls.
module i2c_mem_arbiter #(
  parameter int NREQ        = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ-1:0]   req_wr,
  input  logic [7*NREQ-1:0] req_addr,
  input  logic [8*NREQ-1:0] req_din,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [7:0]        rsp_rdata,
  output logic              rsp_err,
  output logic              mem_wr,
  output logic [6:0]        mem_addr,
  output logic [7:0]        mem_din,
  input  logic [7:0]        mem_datard,
  input  logic              mem_done,
  output logic              busy
);

  localparam int unsigned    N     = NREQ;
  localparam int             PW    = $clog2(NREQ);
  localparam int             TW    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0]  TMAX  = TW'(TIMEOUT_CYC - 1);
  localparam logic [NREQ-1:0] ONE  = NREQ'(1);
  localparam logic [PW-1:0]  PLAST = PW'(NREQ - 1);

  typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_WAIT, S_RESP} state_t;

  state_t          state, state_n;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   owner;
  logic [TW-1:0]   timer;
  logic            mem_done_q;
  logic            done_rise;
  logic            tmo;

  logic            win_found;
  logic [PW-1:0]   win_idx;
  logic            win_wr;
  logic [6:0]      win_addr;
  logic [7:0]      win_din;
  int unsigned     cand;

  assign done_rise = mem_done & ~mem_done_q;
  assign tmo       = (timer == TMAX);
  assign busy      = (state != S_IDLE);
  assign rsp_valid = (state == S_RESP) ? (ONE << owner) : '0;

  // Winner: first valid requester scanning upward from ptr+1, wrapping at NREQ
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_wr    = 1'b0;
    win_addr  = '0;
    win_din   = '0;
    cand      = 0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand = 32'(ptr) + k;
      if (cand >= N) cand = cand - N;
      for (int unsigned i = 0; i < N; i++) begin
        if (!win_found && (i == cand) && req_valid[i]) begin
          win_found = 1'b1;
          win_idx   = PW'(i);
          win_wr    = req_wr[i];
          win_addr  = req_addr[7*i +: 7];
          win_din   = req_din[8*i +: 8];
        end
      end
    end
  end

  // Next-state: a done edge always beats a simultaneous watchdog expiry
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (win_found) state_n = S_FLUSH;
      S_FLUSH: begin
        if (done_rise)  state_n = S_WAIT;
        else if (tmo)   state_n = S_RESP;
      end
      S_WAIT:  if (done_rise || tmo) state_n = S_RESP;
      S_RESP:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // Datapath: command latch, grant pulse, watchdog timer, response capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_done_q <= 1'b0;
      req_ready  <= '0;
      mem_wr     <= 1'b0;
      mem_addr   <= '0;
      mem_din    <= '0;
      owner      <= '0;
      ptr        <= PLAST;
      timer      <= '0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
    end else begin
      mem_done_q <= mem_done;
      req_ready  <= '0;
      case (state)
        S_IDLE: begin
          if (win_found) begin
            mem_wr    <= win_wr;
            mem_addr  <= win_addr;
            mem_din   <= win_din;
            req_ready <= ONE << win_idx;
            owner     <= win_idx;
            ptr       <= win_idx;
            timer     <= '0;
          end
        end
        S_FLUSH, S_WAIT: begin
          if (timer != TMAX) timer <= timer + 1'b1;
          if (done_rise) begin
            if (state == S_WAIT) begin
              rsp_rdata <= mem_wr ? 8'h00 : mem_datard;
              rsp_err   <= 1'b0;
            end
          end else if (tmo) begin
            rsp_rdata <= 8'h00;
            rsp_err   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_mem_arbiter.sv
// Directed bench for i2c_mem_arbiter with a behavioural free-running core
// model and a grant/response scoreboard.
module tb_i2c_mem_arbiter;

  localparam int NREQ = 4;
  localparam int TMO  = 16;
  localparam int P    = 5;   // core transfer period in cycles

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_wr;
  logic [7*NREQ-1:0] req_addr;
  logic [8*NREQ-1:0] req_din;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   rsp_valid;
  logic [7:0]        rsp_rdata;
  logic              rsp_err;
  logic              mem_wr;
  logic [6:0]        mem_addr;
  logic [7:0]        mem_din;
  logic [7:0]        mem_datard;
  logic              mem_done;
  logic              busy;

  always #5 clk = ~clk;

  i2c_mem_arbiter #(.NREQ(NREQ), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_wr(req_wr), .req_addr(req_addr), .req_din(req_din),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_datard(mem_datard), .mem_done(mem_done), .busy(busy)
  );

  typedef struct {
    int         owner;
    logic [7:0] rdata;
    logic       err;
    int         lat;    // -1: don't care
    int         rises;  // -1: don't care
  } exp_t;

  exp_t rspq[$];
  int   grantq[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   rem[NREQ];

  logic [7:0] core_mem[128];
  logic [7:0] ref_mem[128];
  logic       core_en;
  int         ccnt;
  logic       c_wr;
  logic [6:0] c_addr;
  logic [7:0] c_din;

  int         cyc = 0;
  int         grant_cyc = 0;
  int         rises = 0;
  logic       have_cmd;
  logic       granted_now;
  logic       cmd_wr;
  logic [6:0] cmd_addr;
  logic [7:0] cmd_din;
  logic [7:0] last_rdata;

  logic       m_err;
  int         m_lat;
  int         m_rises;
  int         m_rdata;  // -1: take from reference memory

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One clock: observe at the falling edge, score, then drive the core model
  task automatic tick();
    exp_t e;
    int   g;
    @(negedge clk);
    cyc++;
    granted_now = 1'b0;
    if (req_ready != '0) begin
      if (grantq.size() == 0) begin
        chk("grant_unexpected", 32'(req_ready), 0);
      end else begin
        g = grantq.pop_front();
        chk("grant_idx", 32'(req_ready), 32'(1) << g);
        cmd_wr      = req_wr[g];
        cmd_addr    = req_addr[7*g +: 7];
        cmd_din     = req_din[8*g +: 8];
        have_cmd    = 1'b1;
        granted_now = 1'b1;
        grant_cyc   = cyc;
        rises       = 0;
        e.owner = g;
        e.rdata = cmd_wr ? 8'h00 : ref_mem[cmd_addr];
        if (cmd_wr && !m_err) ref_mem[cmd_addr] = cmd_din;
        if (m_err) e.rdata = 8'h00;
        if (m_rdata >= 0) e.rdata = 8'(m_rdata);
        e.err   = m_err;
        e.lat   = m_lat;
        e.rises = m_rises;
        rspq.push_back(e);
        rem[g]--;
        if (rem[g] == 0) req_valid[g] = 1'b0;
      end
    end
    if (have_cmd && busy)
      chk("cmd_stable", {16'h0, mem_wr, mem_addr, mem_din}, {16'h0, cmd_wr, cmd_addr, cmd_din});
    if (rsp_valid != '0) begin
      if (rspq.size() == 0) begin
        chk("rsp_unexpected", 32'(rsp_valid), 0);
      end else begin
        e = rspq.pop_front();
        chk("rsp_owner", 32'(rsp_valid), 32'(1) << e.owner);
        chk("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
        chk("rsp_err", 32'(rsp_err), 32'(e.err));
        if (e.lat >= 0)   chk("rsp_latency", cyc - grant_cyc, e.lat);
        if (e.rises >= 0) chk("done_rises", rises, e.rises);
        last_rdata = e.rdata;
      end
    end
    if (core_en) begin
      if (ccnt == 0) begin
        c_wr = mem_wr; c_addr = mem_addr; c_din = mem_din;
        mem_done = 1'b0;
      end else if (ccnt == 3) begin
        if (busy && rsp_valid == '0) rises++;
        mem_done = 1'b1;
        if (c_wr) core_mem[c_addr] = c_din;
        else      mem_datard = core_mem[c_addr];
      end
      ccnt = (ccnt + 1) % P;
    end
  endtask

  task automatic issue(input int i, input logic wr, input logic [6:0] a,
                       input logic [7:0] d, input int n);
    req_wr[i]          = wr;
    req_addr[7*i +: 7] = a;
    req_din[8*i +: 8]  = d;
    rem[i]             = n;
    req_valid[i]       = 1'b1;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!(rspq.size() == 0 && grantq.size() == 0 && !busy && req_valid == '0) && n < budget) begin
      tick();
      n++;
    end
    chk("wait_budget", 32'(n < budget), 1);
  endtask

  task automatic wait_grant(input int budget);
    int n = 0;
    tick();
    while (!granted_now && n < budget) begin
      tick();
      n++;
    end
    chk("grant_budget", 32'(granted_now), 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    req_valid = '0; req_wr = '0; req_addr = '0; req_din = '0;
    mem_done = 1'b0; mem_datard = 8'h00;
    core_en = 1'b1; ccnt = 0; c_wr = 1'b0; c_addr = '0; c_din = '0;
    have_cmd = 1'b0; granted_now = 1'b0; last_rdata = 8'h00;
    m_err = 1'b0; m_lat = -1; m_rises = 2; m_rdata = -1;
    for (int i = 0; i < NREQ; i++) rem[i] = 0;
    for (int i = 0; i < 128; i++) begin
      core_mem[i] = 8'(i * 7 + 3);
      ref_mem[i]  = 8'(i * 7 + 3);
    end

    #1;
    chk("reset_out_a", {req_ready, rsp_valid, rsp_rdata, rsp_err, busy}, 0);
    chk("reset_out_b", {mem_wr, mem_addr, mem_din}, 0);
    tick(); tick();
    rst = 1'b0;

    // Round-robin from reset: all contend, requester 0 comes back for a second turn
    for (int i = 0; i < NREQ; i++) issue(i, 1'b0, 7'(8'h20 + i), 8'h00, (i == 0) ? 2 : 1);
    grantq.push_back(0); grantq.push_back(1); grantq.push_back(2);
    grantq.push_back(3); grantq.push_back(0);
    wait_done(400);

    // Requester 2 writes 0x15 <= 0xA5, then reads it back
    issue(2, 1'b1, 7'h15, 8'hA5, 1);
    grantq.push_back(2);
    wait_done(100);
    chk("core_mem_written", 32'(core_mem[7'h15]), 32'hA5);
    issue(2, 1'b0, 7'h15, 8'h00, 1);
    grantq.push_back(2);
    wait_done(100);
    tick(); tick(); tick();
    chk("rsp_hold", 32'(rsp_rdata), 32'(last_rdata));

    // Watchdog: core stalls, requester 1 is aborted after 16 cycles
    core_en = 1'b0; mem_done = 1'b0;
    m_err = 1'b1; m_lat = TMO; m_rises = -1;
    issue(1, 1'b0, 7'h30, 8'h00, 1);
    grantq.push_back(1);
    wait_done(100);
    chk("rsp_hold_err", {rsp_err, rsp_rdata}, {1'b1, 8'h00});

    // Core resumes; next request completes normally
    core_en = 1'b1;
    m_err = 1'b0; m_lat = -1; m_rises = 2;
    issue(3, 1'b1, 7'h40, 8'h5A, 1);
    grantq.push_back(3);
    wait_done(100);
    chk("core_mem_written2", 32'(core_mem[7'h40]), 32'h5A);

    // Done edge lands on the watchdog's final WAIT cycle: data wins
    core_en = 1'b0; mem_done = 1'b0; mem_datard = 8'h3C;
    m_lat = TMO; m_rises = -1; m_rdata = 32'h3C;
    issue(0, 1'b0, 7'h50, 8'h00, 1);
    grantq.push_back(0);
    wait_grant(20);
    for (int j = 1; j <= 17; j++) begin
      tick();
      if (j == 2)  mem_done = 1'b1;
      if (j == 3)  mem_done = 1'b0;
      if (j == 15) mem_done = 1'b1;
      if (j == 16) mem_done = 1'b0;
    end
    wait_done(20);
    m_rdata = -1; m_lat = -1; m_rises = 2;
    core_en = 1'b1;

    // Async reset while requester 2 waits for its data
    issue(2, 1'b0, 7'h60, 8'h00, 1);
    grantq.push_back(2);
    wait_grant(20);
    begin
      int n = 0;
      while (rises < 1 && n < 20) begin tick(); n++; end
      chk("reach_wait", 32'(rises), 1);
    end
    tick(); tick();
    chk("busy_before_rst", 32'(busy), 1);
    #1 rst = 1'b1;
    #1;
    chk("arst_out_a", {req_ready, rsp_valid, rsp_rdata, rsp_err, busy}, 0);
    chk("arst_out_b", {mem_wr, mem_addr, mem_din}, 0);
    rspq.delete();
    grantq.delete();
    have_cmd = 1'b0;
    // Without the reset the pointer would favour requester 3 here
    issue(0, 1'b0, 7'h61, 8'h00, 1);
    issue(3, 1'b0, 7'h62, 8'h00, 1);
    grantq.push_back(0); grantq.push_back(3);
    tick(); tick();
    rst = 1'b0;
    wait_done(200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
